// File: rtl/multiply_add.sv
// Sequential signed multiply-add: A = B*Q + R, one multiplier bit per cycle.
// Optional overflow flag enabled with `define MULTIPLY_ADD_OVF_EN.
module multiply_add #(
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [WIDTH-1:0]   Q,
  input  logic signed [WIDTH-1:0]   B,
  input  logic signed [WIDTH-1:0]   R,
  input  logic                      start,
  output logic signed [2*WIDTH-1:0] A,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t                   state;
  logic [2*WIDTH-1:0]       mcand;
  logic [2*WIDTH-1:0]       acc;
  logic [WIDTH-1:0]         mplier;
  logic signed [WIDTH-1:0]  r_q;
  logic                     sign;
  logic [CW-1:0]            cnt;
  logic [WIDTH-1:0]         q_mag;
  logic [WIDTH-1:0]         b_mag;
  logic [2*WIDTH-1:0]       res;

  // Unsigned W-bit magnitudes keep -2^(W-1) exact as 2^(W-1).
  assign q_mag = Q[WIDTH-1] ? $unsigned(-Q) : $unsigned(Q);
  assign b_mag = B[WIDTH-1] ? $unsigned(-B) : $unsigned(B);
  assign res   = (sign ? -acc : acc) + {{WIDTH{r_q[WIDTH-1]}}, r_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      r_q    <= '0;
      sign   <= 1'b0;
      cnt    <= '0;
      A      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand  <= {{WIDTH{1'b0}}, q_mag};
          mplier <= b_mag;
          r_q    <= R;
          sign   <= Q[WIDTH-1] ^ B[WIDTH-1];
          acc    <= '0;
          cnt    <= '0;
          busy   <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          A     <= res;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULTIPLY_ADD_OVF_EN
  logic ovf_q;
  // Result fits in WIDTH signed bits only if the top W+1 bits are a pure sign run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              ovf_q <= 1'b0;
    else if (state == FIX) ovf_q <= !((&res[2*WIDTH-1:WIDTH-1]) || !(|res[2*WIDTH-1:WIDTH-1]));
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_multiply_add.sv
// Directed + randomized bench for multiply_add against a 64-bit arithmetic model.
module tb_multiply_add;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic signed [W-1:0]   Q, B, R;
  logic                  start;
  logic signed [2*W-1:0] A;
  logic                  busy, done, ovf;

  int checks = 0;
  int passes = 0;

  multiply_add #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Q(Q), .B(B), .R(R),
    .start(start), .A(A), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive operands at a negedge; scramble them after the sampling edge.
  task automatic start_op(input logic signed [W-1:0] q, b, r);
    Q = q; B = b; R = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    Q = $urandom; B = $urandom; R = $urandom;
  endtask

  // Cycles elapsed since the sampling edge until done is seen (bounded).
  task automatic wait_done(input bit repulse, output int lat, output logic [63:0] a_mid);
    lat = 0;
    a_mid = 'x;
    while (done !== 1'b1 && lat < 200) begin
      if (repulse && (lat == 5 || lat == 20)) begin
        start = 1'b1; Q = $urandom; B = $urandom; R = $urandom;
      end else start = 1'b0;
      if (lat == 20) a_mid = A;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  function automatic longint model(input logic signed [W-1:0] q, b, r);
    return longint'(b) * longint'(q) + longint'(r);
  endfunction

  function automatic bit model_ovf(input longint v);
`ifdef MULTIPLY_ADD_OVF_EN
    return (v < -longint'(64'sd2147483648)) || (v > longint'(64'sd2147483647));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7fff_ffff;
      2: return 32'hffff_ffff;
      3: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, npulse;
    logic [63:0] a_mid;
    logic signed [W-1:0] q, b, r;
    longint exp_v;

    rst = 1'b0; start = 1'b0; Q = '0; B = '0; R = '0;
    repeat (3) @(negedge clk);
    chk("reset_A", A, 64'd0);
    chk("reset_flags", {61'd0, busy, done, ovf}, 64'd0);
    rst = 1'b1;

    // Basic op: first start right after reset release
    start_op(7, -3, 2);
    chk("busy_run", {63'd0, busy}, 64'd1);
    wait_done(1'b0, lat, a_mid);
    chk("lat_7x-3", lat, LAT);
    chk("A_7x-3", A, 64'(-19));
    chk("ovf_7x-3", {63'd0, ovf}, 64'd0);
    @(negedge clk);
    chk("done_one_cycle", {62'd0, done, busy}, 64'd0);

    // Most negative magnitudes
    start_op(32'h8000_0000, 32'h8000_0000, 0);
    wait_done(1'b0, lat, a_mid);
    chk("lat_min", lat, LAT);
    chk("A_min", A, 64'h4000_0000_0000_0000);
    chk("ovf_min", {63'd0, ovf}, {63'd0, model_ovf(64'sh4000_0000_0000_0000)});
    @(negedge clk);

    // Zero multiplicand with ignored re-pulses while busy
    start_op(0, 12345, -5);
    wait_done(1'b1, lat, a_mid);
    chk("lat_zero", lat, LAT);
    chk("A_zero", A, 64'(-5));
    npulse = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("single_done", npulse, 0);
    chk("A_hold", A, 64'(-5));

    // Reset mid-operation
    start_op(32'h1234_5678, 32'h0765_4321, 9);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_A", A, 64'd0);
    chk("midrst_flags", {61'd0, busy, done, ovf}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    npulse = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("midrst_no_done", npulse, 0);
    start_op(3, 4, 1);
    wait_done(1'b0, lat, a_mid);
    chk("lat_post_rst", lat, LAT);
    chk("A_3x4+1", A, 64'd13);

    // Back-to-back: second start issued in the done cycle
    @(negedge clk);
    start_op(5, 5, 0);
    wait_done(1'b0, lat, a_mid);
    chk("A_5x5", A, 64'd25);
    start_op(-1, 1, 1);
    wait_done(1'b0, lat, a_mid);
    chk("b2b_hold_25", a_mid, 64'd25);
    chk("lat_b2b", lat, LAT);
    chk("A_-1x1+1", A, 64'd0);
    @(negedge clk);

    // Randomized against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      q = pick(); b = pick(); r = pick();
      exp_v = model(q, b, r);
      start_op(q, b, r);
      wait_done(1'b0, lat, a_mid);
      chk($sformatf("rand_A_%0d", i), A, exp_v);
      if (i % 10 == 0) begin
        chk($sformatf("rand_lat_%0d", i), lat, LAT);
        chk($sformatf("rand_ovf_%0d", i), {63'd0, ovf}, {63'd0, model_ovf(exp_v)});
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
